biphase_frame_rx: RTL and testbench

Downstream consumer of the biphase-to-NRZ decoder: takes its per-bit strobe, bit value and line-error pulse and assembles asynchronous-style console frames (start bit 0, DATA_BITS data bits LSB-first, optional even parity, stop bit 1). Good frames are pushed into a small FIFO and presented on a valid/ready byte interface to the keyboard/console protocol logic. Bad frames are dropped and counted, and a hunt state resynchronises on idle marking.

---
 rtl/biphase_frame_rx_if.sv | 11 +
 rtl/biphase_frame_rx.sv | 149 ++++++++++++++
 tb/tb_biphase_frame_rx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/biphase_frame_rx_if.sv
// Byte stream handshake between the frame receiver and the console protocol logic.
interface biphase_frame_rx_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] byte_data;
   logic                 byte_valid;
   logic                 byte_ready;

   modport master (output byte_data, output byte_valid, input byte_ready);
   modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/biphase_frame_rx.sv
// Assembles start/data/[parity]/stop console frames from decoded biphase bits into a byte FIFO.
// Even parity is compiled in when SYMCON_RX_PARITY_EN is defined.
module biphase_frame_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      bit_valid,
   input  logic                      bit_in,
   input  logic                      line_error,
   biphase_frame_rx_if.master        byte_if,
   output logic                      frame_error,
   output logic                      parity_error,
   output logic                      overrun,
   output logic [7:0]                frame_err_count,
   output logic [7:0]                overrun_count
);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {StHunt, StIdle, StData, StParity, StStop} state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 parity_ok;
`ifdef SYMCON_RX_PARITY_EN
   logic                 parity_q, parity_d;
   assign parity_ok = ~^{shift_q, parity_q};
`else
   assign parity_ok = 1'b1;
`endif

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_ptr_q, rd_ptr_q;
   logic                 frame_err_d, par_err_d, good, pop, full, push, ovr_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StHunt;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef SYMCON_RX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
`ifdef SYMCON_RX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next state; line_error overrides any strobe in the same cycle
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
`ifdef SYMCON_RX_PARITY_EN
      parity_d = parity_q;
`endif
      if (line_error) begin
         state_d = StHunt;
      end else if (bit_valid) begin
         unique case (state_q)
            StHunt: if (bit_in) state_d = StIdle;
            StIdle: begin
               if (!bit_in) begin
                  state_d = StData;
                  cnt_d   = '0;
               end
            end
            StData: begin
               shift_d              = shift_q >> 1;
               shift_d[DATA_BITS-1] = bit_in;
               cnt_d                = cnt_q + CntW'(1);
               if (cnt_q == CntW'(DATA_BITS - 1)) begin
`ifdef SYMCON_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
            StParity: begin
`ifdef SYMCON_RX_PARITY_EN
               parity_d = bit_in;
`endif
               state_d = StStop;
            end
            StStop:  state_d = bit_in ? StIdle : StHunt;
            default: state_d = StHunt;
         endcase
      end
   end

   // Frame outcome decode
   always_comb begin
      frame_err_d = 1'b0;
      par_err_d   = 1'b0;
      good        = 1'b0;
      if (line_error) begin
         frame_err_d = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
      end else if (bit_valid && state_q == StStop) begin
         if (!bit_in)         frame_err_d = 1'b1;
         else if (!parity_ok) par_err_d   = 1'b1;
         else                 good        = 1'b1;
      end
   end

   assign byte_if.byte_valid = wr_ptr_q != rd_ptr_q;
   assign byte_if.byte_data  = mem_q[rd_ptr_q[AW-1:0]];

   assign pop  = byte_if.byte_valid && byte_if.byte_ready;
   assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame
   assign push  = good && (!full || pop);
   assign ovr_d = good && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_error     <= 1'b0;
         parity_error    <= 1'b0;
         overrun         <= 1'b0;
         frame_err_count <= '0;
         overrun_count   <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         frame_error  <= frame_err_d;
         parity_error <= par_err_d;
         overrun      <= ovr_d;
         if ((frame_err_d || par_err_d) && frame_err_count != 8'hFF) begin
            frame_err_count <= frame_err_count + 8'd1;
         end
         if (ovr_d && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_biphase_frame_rx.sv
// Bench for biphase_frame_rx: frame-level queue model checked every cycle plus literal spot checks.
module tb_biphase_frame_rx;
`ifdef SYMCON_RX_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif
   localparam int FrameLen = 8 + (ParEn ? 1 : 0) + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic       line_error = 1'b0;
   logic       frame_error, parity_error, overrun;
   logic [7:0] frame_err_count, overrun_count;

   biphase_frame_rx_if #(.DATA_BITS(8)) byte_if ();

   biphase_frame_rx #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bit_valid       (bit_valid),
      .bit_in          (bit_in),
      .line_error      (line_error),
      .byte_if         (byte_if),
      .frame_error     (frame_error),
      .parity_error    (parity_error),
      .overrun         (overrun),
      .frame_err_count (frame_err_count),
      .overrun_count   (overrun_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: 0 hunting, 1 idle, 2 collecting frame bits after a start bit
   int         mode = 0;
   bit         fb[$];
   logic [7:0] mq[$];
   bit         exp_fe = 0, exp_pe = 0, exp_ov = 0, m_good, m_pop;
   int         exp_fec = 0, exp_ovc = 0;
   logic [7:0] m_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode = 0; fb.delete(); mq.delete();
         exp_fe = 0; exp_pe = 0; exp_ov = 0; exp_fec = 0; exp_ovc = 0;
      end else begin
         exp_fe = 0; exp_pe = 0; exp_ov = 0; m_good = 0;
         m_pop = (mq.size() > 0) && byte_if.byte_ready;
         if (line_error) begin
            if (mode == 2) exp_fe = 1;
            mode = 0;
         end else if (bit_valid) begin
            if (mode == 0) begin
               if (bit_in) mode = 1;
            end else if (mode == 1) begin
               if (!bit_in) begin mode = 2; fb.delete(); end
            end else begin
               fb.push_back(bit_in);
               if (fb.size() == FrameLen) begin
                  for (int i = 0; i < 8; i++) m_data[i] = fb[i];
                  if (!fb[FrameLen-1]) begin
                     exp_fe = 1; mode = 0;
                  end else if (ParEn && ((^m_data) ^ fb[8])) begin
                     exp_pe = 1; mode = 1;
                  end else begin
                     m_good = 1; mode = 1;
                  end
               end
            end
         end
         if (m_good && mq.size() == 4 && !m_pop) exp_ov = 1;
         if (m_pop) void'(mq.pop_front());
         if (m_good && !exp_ov) mq.push_back(m_data);
         if ((exp_fe || exp_pe) && exp_fec < 255) exp_fec++;
         if (exp_ov && exp_ovc < 255) exp_ovc++;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("byte_valid", byte_if.byte_valid, mq.size() != 0);
         if (mq.size() != 0) check("byte_data", byte_if.byte_data, mq[0]);
         check("frame_error", frame_error, exp_fe);
         check("parity_error", parity_error, exp_pe);
         check("overrun", overrun, exp_ov);
         check("frame_err_count", frame_err_count, exp_fec);
         check("overrun_count", overrun_count, exp_ovc);
      end
   end

   int fe_seen = 0, pe_seen = 0, ov_seen = 0;
   always @(negedge clk) begin
      if (frame_error) fe_seen++;
      if (parity_error) pe_seen++;
      if (overrun) ov_seen++;
   end

   // Called at posedge+1; leaves one idle cycle after the strobe
   task automatic send_bit(input logic b, input logic rdy);
      bit_valid = 1'b1; bit_in = b; byte_if.byte_ready = rdy;
      @(posedge clk); #1;
      bit_valid = 1'b0; byte_if.byte_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop,
                             input logic par_flip);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
      if (ParEn) send_bit((^d) ^ par_flip, 1'b0);
      send_bit(stop, pop_at_stop);
   endtask

   task automatic pop_one();
      byte_if.byte_ready = 1'b1;
      @(posedge clk); #1;
      byte_if.byte_ready = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " byte_valid"}, byte_if.byte_valid, 0);
      check({tag, " byte_data"}, byte_if.byte_data, 0);
      check({tag, " pulses"}, {frame_error, parity_error, overrun}, 0);
      check({tag, " frame_err_count"}, frame_err_count, 0);
      check({tag, " overrun_count"}, overrun_count, 0);
   endtask

   int fe0, ov0, pe0;

   initial begin
      byte_if.byte_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      started = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Good frame 0xA5
      send_bit(1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check("a5 valid", byte_if.byte_valid, 1);
      check("a5 data", byte_if.byte_data, 8'hA5);
      check("a5 fec", frame_err_count, 0);
      pop_one();
      check("a5 drained", byte_if.byte_valid, 0);

      // Bad stop, zeros ignored in hunt, then a good frame
      fe0 = fe_seen;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check("badstop pulses", fe_seen - fe0, 1);
      check("badstop fec", frame_err_count, 1);
      check("badstop no push", byte_if.byte_valid, 0);
      repeat (3) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      check("3c data", byte_if.byte_data, 8'h3C);
      pop_one();

      // line_error after the 4th data bit, with a strobe in the same cycle
      fe0 = fe_seen;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
      line_error = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      @(posedge clk); #1;
      line_error = 1'b0; bit_valid = 1'b0;
      @(posedge clk); #1;
      check("lerr pulses", fe_seen - fe0, 1);
      check("lerr fec", frame_err_count, 2);
      check("lerr no push", byte_if.byte_valid, 0);
      send_bit(1'b1, 1'b0);

      // Overrun on the fifth frame, then drain in order
      ov0 = ov_seen;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      check("ovr pulses", ov_seen - ov0, 1);
      check("ovr count", overrun_count, 1);
      for (int i = 1; i <= 4; i++) begin
         check("drain order", byte_if.byte_data, i);
         pop_one();
      end
      check("drain empty", byte_if.byte_valid, 0);

      // Push with simultaneous pop at full
      for (int i = 10; i <= 13; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      send_frame(8'd14, 1'b1, 1'b1, 1'b0);
      check("pushpop no ovr", overrun_count, 1);
      for (int i = 11; i <= 14; i++) begin
         check("pushpop order", byte_if.byte_data, i);
         pop_one();
      end

`ifdef SYMCON_RX_PARITY_EN
      pe0 = pe_seen;
      send_frame(8'h01, 1'b1, 1'b0, 1'b1);
      check("parity pulses", pe_seen - pe0, 1);
      check("parity fec", frame_err_count, 3);
      check("parity no push", byte_if.byte_valid, 0);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      check("parity good data", byte_if.byte_data, 8'h01);
      pop_one();
`else
      pe0 = pe_seen;
`endif

      // Reset mid-frame with a byte held in the FIFO
      send_frame(8'h77, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("midreset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_bit(1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check("post reset data", byte_if.byte_data, 8'h5A);
      check("post reset parity pulses", pe_seen - pe0, 0);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
